fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of decode and the sign-extension unit.
- Holds the PC and issues word reads to a 1-cycle-latency instruction memory.
- Buffers returned instructions with their PCs and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects whose target is computed as br_pc + imm_op, where imm_op is the sign-extended immediate produced downstream.

Parameters:
- WIDTH, 32, data/address width in bits.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 2, instruction buffer entries (power of two, >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  WIDTH  word address; bits [1:0] are always 0.
- imem_rdata  in  WIDTH  read data, valid exactly one cycle after imem_req.
- instr_out  out  WIDTH  instruction at buffer head.
- pc_out  out  WIDTH  PC of instr_out.
- instr_valid  out  1  head entry valid.
- instr_ready  in  1  decode accepts head.
- br_taken  in  1  redirect request.
- br_pc  in  WIDTH  PC of the redirecting instruction.
- imm_op  in  WIDTH  sign-extended offset.
- misalign  out  1  registered one-cycle pulse: last redirect target had bits [1:0] != 0.

Behaviour:
- State:
  - fetch_pc register.
  - inflight flag plus inflight_pc.
  - FIFO of {pc, instr}, with count.
- Reset (rst high at a clock edge):
  - fetch_pc <= RESET_PC; inflight <= 0; FIFO emptied; misalign <= 0.
  - While rst is high: imem_req = 0, instr_valid = 0. instr_out and pc_out are don't-care when instr_valid = 0.
- Issue:
  - imem_req = !rst && !br_taken && (count + inflight - pop) < DEPTH, where pop = instr_valid && instr_ready.
  - On issue: imem_addr = fetch_pc; fetch_pc <= fetch_pc + 4, wrapping modulo 2^WIDTH; inflight <= 1; inflight_pc <= fetch_pc.
  - With no issue, inflight <= 0.
- Return:
  - If inflight is set and no squash occurs, {inflight_pc, imem_rdata} is pushed into the FIFO at the clock edge.
  - A push and a pop may occur in the same cycle. The FIFO never overflows, which the issue credit guarantees; the bench asserts this.
- Output:
  - instr_valid = (count != 0) && !br_taken.
  - instr_out and pc_out come from the FIFO head, combinationally.
  - Values at the head are stable while instr_valid = 1 and instr_ready = 0.
- Redirect, when br_taken = 1 in cycle N:
  - target = (br_pc + imm_op), truncated to WIDTH, with bits [1:0] forced to 0.
  - misalign <= |(br_pc + imm_op)[1:0].
  - At edge N: FIFO flushed, any inflight return discarded, fetch_pc <= target, inflight <= 0.
  - No request is issued in cycle N. Redirect takes priority over pop and push in the same cycle.
  - First request goes out in N+1 with imem_addr = target. instr_valid rises in N+3.
  - Back-to-back redirects: the last one wins.
- Latency:
  - After rst is deasserted (cycle 0), the first request is in cycle 0 and instr_valid rises in cycle 2.
  - Steady-state throughput with instr_ready held high is 1 instruction per cycle.
- Stall: with instr_ready = 0, fetch continues until count + inflight = DEPTH, then imem_req stays 0.
- Reset mid-operation overrides everything, including br_taken.

Decomposition:
- fetch_pkg contains:
  - INSTR_BYTES = 4.
  - PC_ALIGN_BITS = 2.
  - typedef fetch_entry_t {logic [WIDTH-1:0] pc; logic [WIDTH-1:0] instr;}.
- One sub-module: fetch_fifo, a synchronous FIFO with parameterised DEPTH, simultaneous push/pop, a synchronous flush input, and a count output.
- PC and credit logic stay in fetch_unit.

Test Plan:
- Reset release, RESET_PC=0, instr_ready=1, memory returns addr^32'hA5A5_0000 -> imem_addr sequence 0,4,8,C on consecutive cycles; instr_valid high from cycle 2; pc_out sequence 0,4,8 with matching instr_out.
- Stall: instr_ready=0 from cycle 2 for 5 cycles -> imem_req stays 0 once count+inflight=2; pc_out holds 0; on release, PCs 0,4,8… arrive with no gap or duplicate.
- Redirect: br_taken=1 with br_pc=0x10, imm_op=0xFFFF_FFF0 -> next imem_addr is 0x0; instr_valid is low in the redirect cycle and through N+2; the first valid pc_out is 0x0; stale PCs 0x14/0x18 never appear.
- Misaligned target: br_pc=0x20, imm_op=0x6 -> imem_addr 0x24 and misalign pulses for exactly one cycle.
- Wrap: redirect target 0xFFFF_FFFC -> subsequent imem_addr is 0x0000_0000; pc_out sequence FFFF_FFFC, 0.
- rst asserted while the FIFO is full and a request is in flight -> the next cycle has instr_valid=0 and imem_req=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared constants and types for the instruction-fetch stage.
//   INSTR_BYTES   : size of one instruction word in bytes (PC step).
//   PC_ALIGN_BITS : number of low PC bits that must be zero for a word address.
//   fetch_entry_t : {pc, instr} pair as buffered by the fetch stage, sized for
//                   the default 32-bit datapath (decode-side consumers use it).
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_WIDTH   = 32;
    localparam int INSTR_BYTES   = 4;
    localparam int PC_ALIGN_BITS = 2;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch stage's three buses:
//     instruction memory : imem_req, imem_addr (out of fetch), imem_rdata (in)
//     decode handshake   : instr_out, pc_out, instr_valid (out), instr_ready (in)
//     redirect           : br_taken, br_pc, imm_op (in), misalign (out)
//   master : the fetch unit's view.
//   slave  : the environment's view (memory, decode, branch resolution).
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;

    logic [WIDTH-1:0] instr_out;
    logic [WIDTH-1:0] pc_out;
    logic             instr_valid;
    logic             instr_ready;

    logic             br_taken;
    logic [WIDTH-1:0] br_pc;
    logic [WIDTH-1:0] imm_op;
    logic             misalign;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output instr_out, pc_out, instr_valid,
        input  instr_ready,
        input  br_taken, br_pc, imm_op,
        output misalign
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  instr_out, pc_out, instr_valid,
        output instr_ready,
        output br_taken, br_pc, imm_op,
        input  misalign
    );

endinterface : fetch_unit_if

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO holding {pc, instr} entries for the fetch stage.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//     flush      : synchronous flush, same effect as rst, wins over push/pop
//     push       : write push_data at the tail this edge
//     push_data  : entry to write
//     pop        : drop the head entry this edge (caller guarantees not empty)
//     head       : current head entry, combinational read
//     count      : number of valid entries, 0..DEPTH
//   Push and pop in the same cycle are both honoured. DEPTH must be a power of
//   two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    // Storage has no reset: contents are only observed once count says valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Holds the PC, issues word reads to a 1-cycle
//   latency instruction memory, buffers returned {pc, instr} pairs and hands
//   them to decode over a valid/ready handshake. Branch/jump redirects arrive
//   as br_pc + imm_op (imm_op already sign-extended downstream).
//   Ports:
//     clk      : clock
//     rst      : synchronous active-high reset, overrides everything
//     bus      : fetch_unit_if.master
//                imem_req/imem_addr -> memory, imem_rdata <- memory (next cycle)
//                instr_out/pc_out/instr_valid -> decode, instr_ready <- decode
//                br_taken/br_pc/imm_op <- redirect, misalign -> one-cycle pulse
//   Flow control: a request is only issued when the buffer is guaranteed to
//   have room for its return, counting the entry leaving this cycle.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       bus
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    logic [WIDTH-1:0] fetch_pc_reg;
    logic             inflight_reg;
    logic [WIDTH-1:0] inflight_pc_reg;
    logic             misalign_reg;

    logic [CW-1:0]    fifo_count;
    entry_t           fifo_head;
    entry_t           fifo_push_data;
    logic             fifo_push;
    logic             fifo_flush;

    logic             instr_valid;
    logic             pop;
    logic             issue;
    logic [CW:0]      occupancy;
    logic [WIDTH-1:0] redirect_sum;
    logic [WIDTH-1:0] redirect_target;

    // Redirect target: sum truncated to WIDTH, forced to a word boundary.
    assign redirect_sum    = bus.br_pc + bus.imm_op;
    assign redirect_target = {redirect_sum[WIDTH-1:PC_ALIGN_BITS],
                              {PC_ALIGN_BITS{1'b0}}};

    // Decode sees nothing while a redirect is being taken or in reset.
    assign instr_valid = !rst && !bus.br_taken && (fifo_count != '0);
    assign pop         = instr_valid && bus.instr_ready;

    // Entries that will be held or owed after this edge if nothing new issues.
    // pop implies fifo_count >= 1, so this cannot underflow.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
    assign issue     = !rst && !bus.br_taken && (occupancy < (CW+1)'(DEPTH));

    // A return in flight during a redirect belongs to the old path: drop it.
    assign fifo_push          = inflight_reg && !bus.br_taken;
    assign fifo_flush         = bus.br_taken;
    assign fifo_push_data.pc    = inflight_pc_reg;
    assign fifo_push_data.instr = bus.imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= RESET_PC;
            misalign_reg    <= 1'b0;
        end else begin
            misalign_reg <= bus.br_taken && (|redirect_sum[PC_ALIGN_BITS-1:0]);
            if (bus.br_taken) begin
                fetch_pc_reg <= redirect_target;
                inflight_reg <= 1'b0;
            end else begin
                inflight_reg <= issue;
                if (issue) begin
                    fetch_pc_reg    <= fetch_pc_reg + WIDTH'(INSTR_BYTES);
                    inflight_pc_reg <= fetch_pc_reg;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_reg;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_out   = fifo_head.instr;
    assign bus.pc_out      = fifo_head.pc;
    assign bus.misalign    = misalign_reg;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed and randomised bench for fetch_unit. The bench plays the
//   instruction memory (data = addr ^ KEY, one cycle after the request) and
//   keeps a queue-based reference of the fetch stage plus an independent
//   expected-PC stream for everything decode accepts.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.WIDTH(32)) bus ();

    fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checks_on   = 1'b0;

    // Reference state
    logic [31:0] m_fetch;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_stream_next;
    bit          m_inflight;
    bit          m_misalign;
    logic [31:0] m_buf[$];

    // Observations of the current cycle
    logic        obs_valid, obs_req, obs_mis;
    logic [31:0] obs_pc, obs_instr, obs_addr;

    // Memory model
    bit          mem_pending;
    logic [31:0] mem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs for the cycle are already applied by the caller.
    task automatic tick();
        bit          e_valid, e_pop, e_req;
        int          occ;
        logic [31:0] sum;
        @(negedge clk);
        obs_valid = bus.instr_valid;
        obs_req   = bus.imem_req;
        obs_mis   = bus.misalign;
        obs_pc    = bus.pc_out;
        obs_instr = bus.instr_out;
        obs_addr  = bus.imem_addr;

        e_valid = !rst && !bus.br_taken && (m_buf.size() != 0);
        e_pop   = e_valid && bus.instr_ready;
        occ     = m_buf.size() + int'(m_inflight) - int'(e_pop);
        e_req   = !rst && !bus.br_taken && (occ < DEPTH);

        if (checks_on) begin
            chk("instr_valid", 32'(obs_valid), 32'(e_valid));
            if (e_valid) begin
                chk("pc_out", obs_pc, m_buf[0]);
                chk("instr_out", obs_instr, m_buf[0] ^ KEY);
            end
            chk("imem_req", 32'(obs_req), 32'(e_req));
            if (e_req) chk("imem_addr", obs_addr, m_fetch);
            chk("misalign", 32'(obs_mis), 32'(m_misalign));
            vectors++;
            assert (int'(dut.u_fifo.count) <= DEPTH) else begin
                miscompares++;
                $error("FAIL fifo_overflow observed=%0d expected<=%0d",
                       dut.u_fifo.count, DEPTH);
            end
            if (e_pop) begin
                chk("stream_pc", obs_pc, m_stream_next);
                $display("accept pc=%h instr=%h", obs_pc, obs_instr);
            end
        end

        mem_pending = (bus.imem_req === 1'b1);
        mem_addr    = bus.imem_addr;

        @(posedge clk);
        if (rst) begin
            m_fetch       = RESET_PC;
            m_inflight    = 1'b0;
            m_buf.delete();
            m_misalign    = 1'b0;
            m_stream_next = RESET_PC;
            checks_on     = 1'b1;
        end else if (bus.br_taken) begin
            sum           = bus.br_pc + bus.imm_op;
            m_fetch       = sum & ~32'h3;
            m_inflight    = 1'b0;
            m_buf.delete();
            m_misalign    = (sum[1:0] != 2'b00);
            m_stream_next = m_fetch;
        end else begin
            m_misalign = 1'b0;
            if (e_pop) begin
                void'(m_buf.pop_front());
                m_stream_next = m_stream_next + 32'd4;
            end
            if (m_inflight) m_buf.push_back(m_inflight_pc);
            if (e_req) begin
                m_inflight    = 1'b1;
                m_inflight_pc = m_fetch;
                m_fetch       = m_fetch + 32'd4;
            end else begin
                m_inflight = 1'b0;
            end
        end

        #1;
        bus.imem_rdata = mem_pending ? (mem_addr ^ KEY) : $urandom();
    endtask

    task automatic redirect(input logic [31:0] pc, input logic [31:0] imm);
        bus.br_taken = 1'b1;
        bus.br_pc    = pc;
        bus.imm_op   = imm;
        tick();
        bus.br_taken = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.br_taken    = 1'b0;
        bus.br_pc       = '0;
        bus.imm_op      = '0;
        bus.instr_ready = 1'b1;
        bus.imem_rdata  = '0;

        // Reset
        tick();
        tick();
        chk("rst_valid", 32'(obs_valid), 32'd0);
        chk("rst_req", 32'(obs_req), 32'd0);
        rst = 1'b0;

        // Release: addresses 0,4,8,C; first valid in cycle 2
        tick(); chk("c0_req", 32'(obs_req), 32'd1); chk("c0_addr", obs_addr, 32'h0);
                chk("c0_valid", 32'(obs_valid), 32'd0);
        tick(); chk("c1_addr", obs_addr, 32'h4); chk("c1_valid", 32'(obs_valid), 32'd0);
        tick(); chk("c2_valid", 32'(obs_valid), 32'd1); chk("c2_pc", obs_pc, 32'h0);
                chk("c2_instr", obs_instr, 32'hA5A5_0000); chk("c2_addr", obs_addr, 32'h8);
        tick(); chk("c3_pc", obs_pc, 32'h4); chk("c3_addr", obs_addr, 32'hC);

        // Stall for 5 cycles: buffer fills, requests stop, head holds
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req", 32'(obs_req), 32'd0);
            chk("stall_pc", obs_pc, 32'h8);
        end
        bus.instr_ready = 1'b1;
        tick(); chk("rel_pc0", obs_pc, 32'h8);  chk("rel_addr0", obs_addr, 32'h10);
        tick(); chk("rel_pc1", obs_pc, 32'hC);  chk("rel_addr1", obs_addr, 32'h14);
        tick(); chk("rel_pc2", obs_pc, 32'h10);

        // Backward redirect to 0x0
        redirect(32'h10, 32'hFFFF_FFF0);
        chk("br_valid", 32'(obs_valid), 32'd0); chk("br_req", 32'(obs_req), 32'd0);
        tick(); chk("br1_addr", obs_addr, 32'h0); chk("br1_valid", 32'(obs_valid), 32'd0);
        tick(); chk("br2_valid", 32'(obs_valid), 32'd0);
        tick(); chk("br3_valid", 32'(obs_valid), 32'd1); chk("br3_pc", obs_pc, 32'h0);

        // Misaligned target 0x26 -> 0x24, one-cycle misalign pulse
        redirect(32'h20, 32'h6);
        chk("mis0", 32'(obs_mis), 32'd0);
        tick(); chk("mis1", 32'(obs_mis), 32'd1); chk("mis1_addr", obs_addr, 32'h24);
        tick(); chk("mis2", 32'(obs_mis), 32'd0);
        tick(); chk("mis3_pc", obs_pc, 32'h24);

        // Wrap from 0xFFFF_FFFC to 0
        redirect(32'hFFFF_FFF0, 32'hC);
        tick(); chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        tick(); chk("wrap_addr1", obs_addr, 32'h0);
        tick(); chk("wrap_pc0", obs_pc, 32'hFFFF_FFFC);
        tick(); chk("wrap_pc1", obs_pc, 32'h0);

        // Reset with a stalled, loaded buffer; rst beats a simultaneous redirect
        bus.instr_ready = 1'b0;
        tick();
        tick();
        rst          = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_pc    = 32'h100;
        bus.imm_op   = 32'h0;
        tick(); chk("mrst_valid", 32'(obs_valid), 32'd0); chk("mrst_req", 32'(obs_req), 32'd0);
        bus.br_taken = 1'b0;
        tick(); chk("mrst2_valid", 32'(obs_valid), 32'd0); chk("mrst2_req", 32'(obs_req), 32'd0);
        rst             = 1'b0;
        bus.instr_ready = 1'b1;
        tick(); chk("mrst_addr", obs_addr, RESET_PC); chk("mrst_req1", 32'(obs_req), 32'd1);
        tick();
        tick(); chk("mrst_pc", obs_pc, RESET_PC);

        // Randomised traffic against the reference
        for (int i = 0; i < 1500; i++) begin
            int off;
            off             = int'($urandom_range(0, 64));
            rst             = ($urandom_range(0, 199) == 0);
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.br_taken    = ($urandom_range(0, 15) == 0);
            bus.br_pc       = $urandom();
            bus.imm_op      = ($urandom_range(0, 1) == 1) ? $urandom() : 32'(off - 32);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_unit
